// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - two-stage RV32I decode/execute issue stage driving the ALU
// Optional: define ALU_ISSUE_BYPASS_EN to forward the output register into stage D operands.
`ifndef ALU_ADD
`define ALU_ADD      4'd0
`define ALU_SUBTRACT 4'd1
`define ALU_AND      4'd2
`define ALU_OR       4'd3
`define ALU_SLL      4'd4
`define ALU_SRL      4'd5
`define ALU_SRA      4'd6
`endif

module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic [3:0]      alu_function,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            dec_legal;
  logic [3:0]      dec_func;
  logic [XLEN-1:0] dec_x, dec_y;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // For I-type, funct7 is imm[11:5]; it only matters for the shift encodings.
  always_comb begin
    dec_legal = 1'b0;
    dec_func  = `ALU_ADD;
    dec_x     = in_rs1_val;
    dec_y     = in_rs2_val;
    if (opcode == OP_I) dec_y = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000: begin
          dec_legal = (opcode == OP_I) || funct7 == 7'h00 || funct7 == 7'h20;
          dec_func  = (opcode == OP_R && funct7[5]) ? `ALU_SUBTRACT : `ALU_ADD;
        end
        3'b111: begin
          dec_legal = (opcode == OP_I) || funct7 == 7'h00;
          dec_func  = `ALU_AND;
        end
        3'b110: begin
          dec_legal = (opcode == OP_I) || funct7 == 7'h00;
          dec_func  = `ALU_OR;
        end
        3'b001: begin
          dec_legal = funct7 == 7'h00;
          dec_func  = `ALU_SLL;
        end
        3'b101: begin
          dec_legal = funct7 == 7'h00 || funct7 == 7'h20;
          dec_func  = funct7[5] ? `ALU_SRA : `ALU_SRL;
        end
        default: dec_legal = 1'b0;
      endcase
    end else if (opcode == OP_LUI) begin
      dec_legal = 1'b1;
      dec_x     = '0;
      dec_y     = XLEN'({in_instr[31:12], 12'h000});
    end
    if (!dec_legal) begin
      dec_func = `ALU_ADD;
      dec_x    = '0;
      dec_y    = '0;
    end
  end

  logic            dstg_valid_q, dstg_illegal_q;
  logic [3:0]      dstg_func_q;
  logic [XLEN-1:0] dstg_x_q, dstg_y_q;
  logic [4:0]      dstg_rd_q;
  logic            out_valid_q, out_illegal_q;
  logic [4:0]      out_rd_q;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            d_adv, accept;

  assign d_adv    = !out_valid_q || out_ready;
  assign in_ready = !dstg_valid_q || d_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstg_valid_q   <= 1'b0;
      dstg_illegal_q <= 1'b0;
      dstg_func_q    <= `ALU_ADD;
      dstg_x_q       <= '0;
      dstg_y_q       <= '0;
      dstg_rd_q      <= '0;
    end else if (accept) begin
      dstg_valid_q   <= 1'b1;
      dstg_illegal_q <= !dec_legal;
      dstg_func_q    <= dec_func;
      dstg_x_q       <= dec_x;
      dstg_y_q       <= dec_y;
      dstg_rd_q      <= dec_legal ? in_instr[11:7] : 5'd0;
    end else if (d_adv) begin
      dstg_valid_q   <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_BYPASS_EN
  logic [4:0] dstg_rs1_q, dstg_rs2_q;
  logic       dstg_fx_q, dstg_fy_q, fwd_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstg_rs1_q <= '0;
      dstg_rs2_q <= '0;
      dstg_fx_q  <= 1'b0;
      dstg_fy_q  <= 1'b0;
    end else if (accept) begin
      dstg_rs1_q <= in_instr[19:15];
      dstg_rs2_q <= in_instr[24:20];
      dstg_fx_q  <= dec_legal && (opcode == OP_R || opcode == OP_I) && in_instr[19:15] != 5'd0;
      dstg_fy_q  <= dec_legal && opcode == OP_R && in_instr[24:20] != 5'd0;
    end
  end

  // Forwarding ignores out_ready: the output register holds its value while stalled.
  assign fwd_ok = out_valid_q && !out_illegal_q && out_rd_q != 5'd0;
  assign alu_x  = (fwd_ok && dstg_fx_q && dstg_rs1_q == out_rd_q) ? out_result_q : dstg_x_q;
  assign alu_y  = (fwd_ok && dstg_fy_q && dstg_rs2_q == out_rd_q) ? out_result_q : dstg_y_q;
`else
  assign alu_x = dstg_x_q;
  assign alu_y = dstg_y_q;
`endif

  assign alu_function = dstg_func_q;
  assign out_result_d = (dstg_rd_q == 5'd0) ? '0 : alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      out_rd_q      <= '0;
      out_result_q  <= '0;
    end else if (d_adv) begin
      out_valid_q <= dstg_valid_q;
      if (dstg_valid_q) begin
        out_illegal_q <= dstg_illegal_q;
        out_rd_q      <= dstg_rd_q;
        out_result_q  <= out_result_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_rd      = out_rd_q;
  assign out_result  = out_result_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with an instruction-level reference model
`ifndef ALU_ADD
`define ALU_ADD      4'd0
`define ALU_SUBTRACT 4'd1
`define ALU_AND      4'd2
`define ALU_OR       4'd3
`define ALU_SLL      4'd4
`define ALU_SRL      4'd5
`define ALU_SRA      4'd6
`endif

module tb_alu_issue;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_rs1_val = '0, in_rs2_val = '0;
  logic [3:0]  alu_function;
  logic [31:0] alu_x, alu_y, alu_result;
  logic        out_valid, out_ready = 1'b0, out_illegal;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        rnd_rdy = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int di;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_function(alu_function), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins, a, b;
    logic        ill;
    logic [4:0]  rd;
    logic [3:0]  fn;
    logic [31:0] x, y, res;
  } ent_t;

  ent_t q[$];

  function automatic logic [31:0] calc(input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y);
    case (fn)
      `ALU_ADD:      return x + y;
      `ALU_SUBTRACT: return x - y;
      `ALU_AND:      return x & y;
      `ALU_OR:       return x | y;
      `ALU_SLL:      return x << y[4:0];
      `ALU_SRL:      return x >> y[4:0];
      `ALU_SRA:      return $unsigned($signed(x) >>> y[4:0]);
      default:       return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb alu_result = calc(alu_function, alu_x, alu_y);

  // Reference: instruction semantics; fv/frd/fval describe the older result still in the output slot.
  function automatic ent_t model(input logic [31:0] ins, input logic [31:0] a_in, input logic [31:0] b_in,
                                 input logic fv, input logic [4:0] frd, input logic [31:0] fval);
    ent_t e;
    logic [31:0] a, b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ok;
    e = '0;
    e.ins = ins; e.a = a_in; e.b = b_in;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = a_in; b = b_in;
    if (BYP && fv && frd != 5'd0 && frd == ins[19:15]) a = fval;
    if (BYP && fv && frd != 5'd0 && frd == ins[24:20]) b = fval;
    ok = 1'b1;
    e.fn = `ALU_ADD;
    if (op == 7'h33) begin
      e.x = a; e.y = b;
      if (f7 == 7'h00 && f3 == 3'd0) e.fn = `ALU_ADD;
      else if (f7 == 7'h00 && f3 == 3'd7) e.fn = `ALU_AND;
      else if (f7 == 7'h00 && f3 == 3'd6) e.fn = `ALU_OR;
      else if (f7 == 7'h00 && f3 == 3'd1) e.fn = `ALU_SLL;
      else if (f7 == 7'h00 && f3 == 3'd5) e.fn = `ALU_SRL;
      else if (f7 == 7'h20 && f3 == 3'd0) e.fn = `ALU_SUBTRACT;
      else if (f7 == 7'h20 && f3 == 3'd5) e.fn = `ALU_SRA;
      else ok = 1'b0;
    end else if (op == 7'h13) begin
      e.x = a; e.y = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd0) e.fn = `ALU_ADD;
      else if (f3 == 3'd7) e.fn = `ALU_AND;
      else if (f3 == 3'd6) e.fn = `ALU_OR;
      else if (f3 == 3'd1 && f7 == 7'h00) e.fn = `ALU_SLL;
      else if (f3 == 3'd5 && f7 == 7'h00) e.fn = `ALU_SRL;
      else if (f3 == 3'd5 && f7 == 7'h20) e.fn = `ALU_SRA;
      else ok = 1'b0;
    end else if (op == 7'h37) begin
      e.x = 32'd0; e.y = {ins[31:12], 12'h000};
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      e.fn = `ALU_ADD; e.x = 0; e.y = 0; e.ill = 1'b1; e.rd = 0; e.res = 0;
    end else begin
      e.ill = 1'b0;
      e.rd  = ins[11:7];
      e.res = (e.rd == 5'd0) ? 32'd0 : calc(e.fn, e.x, e.y);
    end
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("inflight", 32'(q.size() <= (out_valid ? 2 : 1)), 32'd1);
      if (out_valid) begin
        if (q.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
        else begin
          chk("out_rd", 32'(out_rd), 32'(q[0].rd));
          chk("out_result", out_result, q[0].res);
          chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
      end
      di = out_valid ? 1 : 0;
      if (q.size() > di) begin
        if (di == 1) q[1] = model(q[1].ins, q[1].a, q[1].b, 1'b1, q[0].rd, q[0].res);
        else         q[0] = model(q[0].ins, q[0].a, q[0].b, 1'b0, 5'd0, 32'd0);
        chk("alu_function", 32'(alu_function), 32'(q[di].fn));
        chk("alu_x", alu_x, q[di].x);
        chk("alu_y", alu_y, q[di].y);
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(in_instr, in_rs1_val, in_rs2_val, 1'b0, 5'd0, 32'd0));
    end
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_instr = ins; in_rs1_val = a; in_rs2_val = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic one(input string nm, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] rd, input logic [31:0] res, input logic ill);
    send(ins, a, b);
    chk({nm, "_fn"}, 32'(alu_function), 32'(fn));
    chk({nm, "_x"}, alu_x, x);
    chk({nm, "_y"}, alu_y, y);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_rd"}, 32'(out_rd), 32'(rd));
    chk({nm, "_res"}, out_result, res);
    chk({nm, "_ill"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_alu_y", alu_y, 32'd0);
    chk("rst_alu_fn", 32'(alu_function), 32'(`ALU_ADD));
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    one("add",  r_ins(7'h00, 2, 1, 3'd0, 3), 5, 7, `ALU_ADD, 5, 7, 3, 12, 0);
    one("sub",  r_ins(7'h20, 2, 1, 3'd0, 4), 5, 7, `ALU_SUBTRACT, 5, 7, 4, 32'hFFFFFFFE, 0);
    one("addi", i_ins(12'hFFF, 0, 3'd0, 5), 0, 0, `ALU_ADD, 0, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 0);
    one("lui",  {20'h12345, 5'd6, 7'h37}, 32'hDEAD, 0, `ALU_ADD, 0, 32'h12345000, 6, 32'h12345000, 0);
    one("srai", i_ins(12'h404, 1, 3'd5, 7), 32'h80000000, 0, `ALU_SRA, 32'h80000000, 32'h404, 7, 32'hF8000000, 0);
    one("xor",  r_ins(7'h00, 2, 1, 3'd4, 8), 5, 7, `ALU_ADD, 0, 0, 0, 0, 1);
    one("rd0",  r_ins(7'h00, 2, 1, 3'd0, 0), 5, 7, `ALU_ADD, 5, 7, 0, 0, 0);
    one("f7bad", r_ins(7'h01, 2, 1, 3'd0, 9), 5, 7, `ALU_ADD, 0, 0, 0, 0, 1);
    one("sllibad", i_ins(12'h401, 1, 3'd1, 9), 5, 7, `ALU_ADD, 0, 0, 0, 0, 1);
    one("load", {12'h004, 5'd1, 3'd2, 5'd9, 7'h03}, 5, 7, `ALU_ADD, 0, 0, 0, 0, 1);
    one("addineg", i_ins(12'hFF0, 1, 3'd0, 9), 100, 0, `ALU_ADD, 100, 32'hFFFFFFF0, 9, 32'h54, 0);
    one("srli", i_ins(12'h01F, 1, 3'd5, 10), 32'h80000000, 0, `ALU_SRL, 32'h80000000, 32'h1F, 10, 1, 0);
    one("sra",  r_ins(7'h20, 2, 1, 3'd5, 11), 32'hF0000000, 32'h24, `ALU_SRA, 32'hF0000000, 32'h24, 11, 32'hFF000000, 0);
    one("andbad", r_ins(7'h20, 2, 1, 3'd7, 12), 5, 7, `ALU_ADD, 0, 0, 0, 0, 1);
    drain();

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = r_ins(7'h00, 2, 1, 3'd0, 9); in_rs1_val = 1; in_rs2_val = 2;
    @(negedge clk); chk("stall_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_instr = r_ins(7'h00, 2, 1, 3'd0, 10); in_rs1_val = 3; in_rs2_val = 4;
    @(negedge clk); chk("stall_rdy2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_instr = r_ins(7'h00, 2, 1, 3'd0, 11); in_rs1_val = 10; in_rs2_val = 20;
    @(negedge clk); chk("stall_rdy3", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("stall_hold_valid", 32'(out_valid), 32'd1);
    chk("stall_hold_rd", 32'(out_rd), 32'd9);
    chk("stall_hold_res", out_result, 32'd3);
    chk("stall_rdy4", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(r_ins(7'h00, 2, 1, 3'd0, 11), 10, 20);
    chk("order_b_rd", 32'(out_rd), 32'd10);
    chk("order_b_res", out_result, 32'd7);
    @(posedge clk); #1;
    chk("order_c_rd", 32'(out_rd), 32'd11);
    chk("order_c_res", out_result, 32'd30);
    drain();

    out_ready = 1'b0;
    send(r_ins(7'h00, 2, 1, 3'd0, 12), 1, 1);
    send(r_ins(7'h00, 2, 1, 3'd0, 13), 2, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    send(i_ins(12'd9, 0, 3'd0, 1), 0, 0);
    send(r_ins(7'h00, 1, 1, 3'd0, 2), 0, 0);
    chk("byp_first_res", out_result, 32'd9);
    chk("byp_alu_x", alu_x, BYP ? 32'd9 : 32'd0);
    @(posedge clk); #1;
    chk("byp_rd", 32'(out_rd), 32'd2);
    chk("byp_res", out_result, BYP ? 32'd18 : 32'd0);
    drain();

    rnd_rdy = 1'b1;
    send(r_ins(7'h00, 2, 1, 3'd7, 3), 32'hF0F0F0F0, 32'hFF00FF00);
    send(r_ins(7'h00, 2, 3, 3'd6, 4), 32'h0000000F, 32'h00F00000);
    send(r_ins(7'h00, 1, 4, 3'd1, 5), 32'h00000023, 32'h1);
    send(r_ins(7'h00, 1, 5, 3'd5, 6), 32'h80000000, 31);
    send(r_ins(7'h20, 1, 6, 3'd5, 7), 32'h80000000, 32'h21);
    send(i_ins(12'h0FF, 7, 3'd7, 1), 32'h12345678, 0);
    send(i_ins(12'hFFF, 1, 3'd6, 2), 32'h00000001, 0);
    send(i_ins(12'h01F, 2, 3'd1, 3), 32'h00000003, 0);
    send(i_ins(12'h001, 3, 3'd5, 4), 32'h80000000, 0);
    send(r_ins(7'h00, 1, 1, 3'd0, 1), 32'h40000000, 32'h40000000);
    send(r_ins(7'h20, 1, 1, 3'd0, 2), 32'h11, 32'h22);
    send(r_ins(7'h00, 2, 1, 3'd3, 5), 5, 7);
    send({20'hFFFFF, 5'd6, 7'h37}, 0, 0);
    send(r_ins(7'h00, 6, 6, 3'd0, 7), 1, 2);
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
